// File: rtl/leiwand_rv32_uart_rx_pkg.sv
// Shared constants for the memory-mapped UART receiver: bus widths, register offsets,
// STATUS/CTRL bit positions and the receive state encoding.
package leiwand_rv32_uart_rx_pkg;

    localparam int XLEN            = 32;
    localparam int MEM_WIDTH_BYTES = XLEN / 8;

    localparam logic [1:0] RX_REG_DATA   = 2'd0;
    localparam logic [1:0] RX_REG_STATUS = 2'd1;
    localparam logic [1:0] RX_REG_CTRL   = 2'd2;

    localparam int STATUS_NOT_EMPTY = 0;
    localparam int STATUS_FULL      = 1;
    localparam int STATUS_OVERRUN   = 2;
    localparam int STATUS_FRAME_ERR = 3;

    localparam int CTRL_IRQ_EN = 0;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/leiwand_rv32_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full is accepted only when
// a pop happens in the same cycle.
module leiwand_rv32_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/leiwand_rv32_uart_rx.sv
// 8N1 serial receiver with receive FIFO, STATUS/CTRL registers and a level interrupt,
// acting as a target on the valid/ready memory bus.
module leiwand_rv32_uart_rx
    import leiwand_rv32_uart_rx_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid,
    output logic                       ready,
    input  logic [MEM_WIDTH_BYTES-1:0] wen,
    input  logic [XLEN-1:0]            addr,
    input  logic [XLEN-1:0]            wdata,
    output logic [XLEN-1:0]            rdata,
    input  logic                       rx,
    output logic                       irq_out
);

    localparam int CNT_W  = $clog2(CLK_DIV);
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

    rx_state_t          rx_state, rx_state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [2:0]         bit_idx, bit_idx_next;
    logic [7:0]         shift, shift_next;
    logic               rx_s1, rx_s2, rx_prev, rx_fall;
    logic               rx_push, frame_err_set;

    logic               fifo_pop, fifo_full, fifo_empty;
    logic [7:0]         fifo_dout;
    logic [FCNT_W-1:0]  fifo_count;

    logic               overrun, frame_err, irq_en;
    logic               acc, is_read, overrun_set, clr_overrun, clr_frame_err;
    logic [1:0]         reg_sel;
    logic [XLEN-1:0]    rd_value;
    logic               unused_bits;

    // Synchroniser plus one extra stage so a falling edge is seen on clean data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall = rx_prev && !rx_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            rx_state <= rx_state_next;
            cnt      <= cnt_next;
            bit_idx  <= bit_idx_next;
            shift    <= shift_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state;
        cnt_next      = cnt;
        bit_idx_next  = bit_idx;
        shift_next    = shift;
        rx_push       = 1'b0;
        frame_err_set = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_state_next = RX_START;
                    cnt_next      = CNT_W'(CLK_DIV / 2 - 1);
                end
            end
            RX_START: begin
                if (cnt == '0) begin
                    if (!rx_s2) begin
                        rx_state_next = RX_DATA;
                        cnt_next      = CNT_W'(CLK_DIV - 1);
                        bit_idx_next  = 3'd0;
                    end else begin
                        rx_state_next = RX_IDLE;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt == '0) begin
                    shift_next = {rx_s2, shift[7:1]};
                    cnt_next   = CNT_W'(CLK_DIV - 1);
                    if (bit_idx == 3'd7) begin
                        rx_state_next = RX_STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt == '0) begin
                    rx_push       = rx_s2;
                    frame_err_set = !rx_s2;
                    rx_state_next = RX_IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    leiwand_rv32_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (fifo_pop),
        .din   (shift),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Bus: a request is taken when valid meets a low ready; reads pop and writes
    // update registers on that edge, the same edge that raises ready and rdata.
    assign acc           = valid && !ready;
    assign is_read       = (wen == '0);
    assign reg_sel       = addr[3:2];
    assign fifo_pop      = acc && is_read && (reg_sel == RX_REG_DATA) && !fifo_empty;
    assign overrun_set   = rx_push && fifo_full && !fifo_pop;
    assign clr_overrun   = acc && wen[0] && (reg_sel == RX_REG_STATUS) && wdata[STATUS_OVERRUN];
    assign clr_frame_err = acc && wen[0] && (reg_sel == RX_REG_STATUS) && wdata[STATUS_FRAME_ERR];

    always_comb begin
        rd_value = '0;
        case (reg_sel)
            RX_REG_DATA: begin
                if (!fifo_empty) rd_value[8:0] = {1'b1, fifo_dout};
            end
            RX_REG_STATUS: begin
                rd_value[STATUS_NOT_EMPTY] = !fifo_empty;
                rd_value[STATUS_FULL]      = fifo_full;
                rd_value[STATUS_OVERRUN]   = overrun;
                rd_value[STATUS_FRAME_ERR] = frame_err;
            end
            RX_REG_CTRL: rd_value[CTRL_IRQ_EN] = irq_en;
            default:     rd_value = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready     <= 1'b0;
            rdata     <= '0;
            irq_out   <= 1'b0;
            irq_en    <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            ready     <= acc;
            rdata     <= (acc && is_read) ? rd_value : '0;
            irq_out   <= irq_en && !fifo_empty;
            overrun   <= overrun_set || (overrun && !clr_overrun);
            frame_err <= frame_err_set || (frame_err && !clr_frame_err);
            if (acc && wen[0] && (reg_sel == RX_REG_CTRL)) begin
                irq_en <= wdata[CTRL_IRQ_EN];
            end
        end
    end

    assign unused_bits = ^{addr[XLEN-1:4], addr[1:0], wdata[XLEN-1:4], wdata[1], fifo_count};

endmodule

// File: tb/tb_leiwand_rv32_uart_rx.sv
// Directed bench for leiwand_rv32_uart_rx: serial frames in, register reads out,
// received bytes tracked in an expected queue.
module tb_leiwand_rv32_uart_rx;
    import leiwand_rv32_uart_rx_pkg::*;

    localparam int BIT = 16;
    localparam logic [31:0] A_DATA   = 32'h0;
    localparam logic [31:0] A_STATUS = 32'h4;
    localparam logic [31:0] A_CTRL   = 32'h8;
    localparam logic [31:0] A_RSVD   = 32'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        ready;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rx;
    logic        irq_out;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    leiwand_rv32_uart_rx #(.CLK_DIV(BIT), .FIFO_DEPTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .valid   (valid),
        .ready   (ready),
        .wen     (wen),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .rx      (rx),
        .irq_out (irq_out)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic bus(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                       output logic [31:0] rd);
        int n;
        @(negedge clk);
        valid = 1'b1; addr = a; wen = we; wdata = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 8);
        rd = rdata;
        valid = 1'b0; wen = '0; wdata = '0;
        check("ready_latency", 32'(n), 32'd1);
    endtask

    task automatic read_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        bus(a, 4'b0000, 32'h0, rd);
        check(tag, rd, exp);
    endtask

    task automatic write_reg(input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] rd;
        bus(a, 4'b0001, wd, rd);
    endtask

    task automatic read_fifo(input string tag);
        logic [31:0] exp;
        exp = (exp_q.size() > 0) ? {23'h0, 1'b1, exp_q.pop_front()} : 32'h0;
        read_reg(tag, A_DATA, exp);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Directed sequence
    initial begin
        logic [3:0]  seq;
        logic [7:0]  partial;
        rst = 1'b1; valid = 1'b0; wen = '0; addr = '0; wdata = '0; rx = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_irq", 32'(irq_out), 32'd0);
        check("reset_state", 32'(dut.rx_state), 32'(RX_IDLE));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        read_reg("reset_status", A_STATUS, 32'h0);
        read_reg("reset_ctrl", A_CTRL, 32'h0);

        // 1: basic byte
        send_frame(8'h55, 1'b1); exp_q.push_back(8'h55);
        read_reg("t1_status", A_STATUS, 32'h1);
        read_fifo("t1_rxdata");
        read_reg("t1_status_after", A_STATUS, 32'h0);
        read_reg("t1_reserved", A_RSVD, 32'h0);

        // held valid acknowledges every other cycle
        @(negedge clk);
        valid = 1'b1; addr = A_STATUS; wen = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seq[i] = ready;
        end
        valid = 1'b0;
        check("held_valid_pulses", 32'(seq), 32'h5);
        @(negedge clk);
        check("rdata_idle_zero", rdata, 32'h0);

        // 2: interrupt
        write_reg(A_CTRL, 32'h1);
        read_reg("t2_ctrl", A_CTRL, 32'h1);
        check("t2_irq_idle", 32'(irq_out), 32'd0);
        send_frame(8'hA3, 1'b1); exp_q.push_back(8'hA3);
        check("t2_irq_high", 32'(irq_out), 32'd1);
        read_fifo("t2_rxdata");
        @(negedge clk);
        check("t2_irq_fall", 32'(irq_out), 32'd0);
        write_reg(A_CTRL, 32'h0);

        // 3: overrun
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 1'b1);
            if (i <= 8) exp_q.push_back(8'(i));
        end
        read_reg("t3_status_full_ovr", A_STATUS, 32'h7);
        for (int i = 0; i < 8; i++) read_fifo("t3_rxdata");
        write_reg(A_STATUS, 32'h4);
        read_reg("t3_status_cleared", A_STATUS, 32'h0);
        read_fifo("t3_empty_read");

        // RXDATA writes are acknowledged but leave the FIFO alone
        send_frame(8'hC7, 1'b1); exp_q.push_back(8'hC7);
        write_reg(A_DATA, 32'hFF);
        read_fifo("wr_data_ignored");

        // 4: frame error
        send_frame(8'h3C, 1'b0);
        read_reg("t4_status_ferr", A_STATUS, 32'h8);
        read_reg("t4_rxdata_empty", A_DATA, 32'h0);
        write_reg(A_STATUS, 32'h8);
        read_reg("t4_status_cleared", A_STATUS, 32'h0);

        // 5: glitch rejection
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("t5_glitch_idle", 32'(dut.rx_state), 32'(RX_IDLE));
        read_reg("t5_status", A_STATUS, 32'h0);
        send_frame(8'h7E, 1'b1); exp_q.push_back(8'h7E);
        read_fifo("t5_rxdata");

        // 6: reset in the middle of data bit 4
        partial = 8'h99;
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = partial[i];
            repeat (BIT) @(negedge clk);
        end
        rx = partial[4];
        repeat (BIT / 2) @(negedge clk);
        check("t6_in_data", 32'(dut.rx_state), 32'(RX_DATA));
        rst = 1'b1;
        rx = 1'b1;
        @(negedge clk);
        check("t6_reset_idle", 32'(dut.rx_state), 32'(RX_IDLE));
        @(negedge clk);
        rst = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        send_frame(8'h42, 1'b1); exp_q.push_back(8'h42);
        read_reg("t6_status", A_STATUS, 32'h1);
        read_fifo("t6_rxdata");
        read_reg("t6_status_after", A_STATUS, 32'h0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
